// File: rtl/mux_2to1.sv
// ---------------------------------------------------------------------------
// mux_2to1
//
// Purpose:
//   2:1 selector with a zero-latency combinational result and a registered
//   copy. It also keeps a registered copy of the select and a free-running
//   count of select changes, for debug and coverage. Used as a leaf datapath
//   primitive wherever two sources share one sink.
//
// Parameters:
//   WIDTH        data width of a, b, out and out_q
//   CNT_W        width of the select-toggle counter
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   a            data input 0, chosen when s = 0
//   b            data input 1, chosen when s = 1
//   s            select
//   en           load enable for out_q
//   out          combinational select result (s ? b : a)
//   out_q        registered select result, loaded when en = 1
//   sel_q        registered copy of s, updated on every edge
//   sel_toggles  count of edges where s differed from sel_q, wraps
// ---------------------------------------------------------------------------
module mux_2to1 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_q,
    output logic [CNT_W-1:0] sel_toggles
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             sel_state_q;
    logic             sel_state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The ternary is left as-is so an unknown select propagates as X in
    // simulation instead of being masked to one of the inputs.
    assign out = s ? b : a;

    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path leaves a variable unassigned and no latch is inferred.
        data_d      = data_q;
        sel_state_d = s;
        cnt_d       = cnt_q;

        if (en) begin
            data_d = out;
        end

        // Compared against the pre-edge copy of the select, so the first
        // edge after reset with s = 1 counts as a change.
        if (s != sel_state_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: the reset term is in the sensitivity list, so the registers clear
    // immediately on rst_n falling, and reset dominates a coincident clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            sel_state_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // pre-edge values regardless of statement order.
            data_q      <= data_d;
            sel_state_q <= sel_state_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_q       = data_q;
    assign sel_q       = sel_state_q;
    assign sel_toggles = cnt_q;

endmodule

// File: tb/tb_mux_2to1.sv
module tb_mux_2to1;

    logic       clk;
    logic       rst_n;

    // WIDTH = 1 instance
    logic       a1, b1, s1, en1;
    logic       out1, out_q1, sel_q1;
    logic [7:0] cnt1;

    // WIDTH = 8 instance
    logic [7:0] a8, b8;
    logic       s8, en8;
    logic [7:0] out8, out_q8;
    logic       sel_q8;
    logic [7:0] cnt8;

    int passed;
    int total;

    mux_2to1 #(.WIDTH(1), .CNT_W(8)) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a1),
        .b           (b1),
        .s           (s1),
        .en          (en1),
        .out         (out1),
        .out_q       (out_q1),
        .sel_q       (sel_q1),
        .sel_toggles (cnt1)
    );

    mux_2to1 #(.WIDTH(8), .CNT_W(8)) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a8),
        .b           (b8),
        .s           (s8),
        .en          (en8),
        .out         (out8),
        .out_q       (out_q8),
        .sel_q       (sel_q8),
        .sel_toggles (cnt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b0; s1 = 1'b1; en1 = 1'b1;
        a8 = 8'h00; b8 = 8'h00; s8 = 1'b0; en8 = 1'b0;
        #2;
        total++;
        if ({out_q1, sel_q1, cnt1} !== 10'd0) $display("FAIL reset_immediate got out_q=%b sel_q=%b cnt=%0d want 0/0/0", out_q1, sel_q1, cnt1);
        else passed++;
        tick();
        tick();
        total++;
        if ({out_q1, sel_q1, cnt1} !== 10'd0) $display("FAIL reset_held got out_q=%b sel_q=%b cnt=%0d want 0/0/0", out_q1, sel_q1, cnt1);
        else passed++;
        total++;
        if (out1 !== 1'b0) $display("FAIL reset_out_tracks got %b want 0", out1);
        else passed++;
        s1 = 1'b0;
        #1;
        total++;
        if (out1 !== 1'b1) $display("FAIL reset_out_tracks2 got %b want 1", out1);
        else passed++;
    endtask

    task automatic test_truth_table();
        logic [3:0] vec [4];
        vec[0] = 4'b000_0; // a b s -> out
        vec[1] = 4'b011_1;
        vec[2] = 4'b101_0;
        vec[3] = 4'b110_1;
        for (int i = 0; i < 4; i++) begin
            a1 = vec[i][3]; b1 = vec[i][2]; s1 = vec[i][1];
            #10;
            total++;
            if (out1 !== vec[i][0]) $display("FAIL truth_table[%0d] got %b want %b", i, out1, vec[i][0]);
            else passed++;
        end
    endtask

    task automatic test_latency();
        // Release reset mid-cycle, then set inputs before the first edge.
        @(negedge clk);
        rst_n = 1'b1;
        en1 = 1'b1; a1 = 1'b1; b1 = 1'b0; s1 = 1'b0;
        #1;
        total++;
        if (out_q1 !== 1'b0) $display("FAIL latency_before got %b want 0", out_q1);
        else passed++;
        tick();
        total++;
        if (out_q1 !== 1'b1) $display("FAIL latency_after got %b want 1", out_q1);
        else passed++;
        s1 = 1'b1;
        tick();
        total++;
        if (out_q1 !== 1'b0) $display("FAIL latency_s1 got %b want 0", out_q1);
        else passed++;
        total++;
        if (sel_q1 !== 1'b1 || cnt1 !== 8'd1) $display("FAIL latency_sel got sel_q=%b cnt=%0d want 1/1", sel_q1, cnt1);
        else passed++;
    endtask

    task automatic test_enable_hold();
        s1 = 1'b0; a1 = 1'b1;
        tick();
        total++;
        if (out_q1 !== 1'b1) $display("FAIL hold_load got %b want 1", out_q1);
        else passed++;
        en1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (out_q1 !== 1'b1 || out1 !== 1'b0) $display("FAIL hold[%0d] got out_q=%b out=%b want 1/0", i, out_q1, out1);
            else passed++;
        end
        // s went 1 -> 0 on the load edge, the only change since the last check.
        total++;
        if (cnt1 !== 8'd2) $display("FAIL hold_cnt got %0d want 2", cnt1);
        else passed++;
    endtask

    task automatic test_toggle_count();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        en1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s1 = (i % 2 == 0);
            tick();
        end
        total++;
        if (cnt1 !== 8'd5 || sel_q1 !== 1'b1 || out_q1 !== 1'b1) $display("FAIL toggle5 got cnt=%0d sel_q=%b out_q=%b want 5/1/1", cnt1, sel_q1, out_q1);
        else passed++;
    endtask

    task automatic test_async_reset();
        a1 = 1'b0; b1 = 1'b1; s1 = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_q1, sel_q1, cnt1} !== 10'd0) $display("FAIL async_reset got out_q=%b sel_q=%b cnt=%0d want 0/0/0", out_q1, sel_q1, cnt1);
        else passed++;
        total++;
        if (out1 !== 1'b1) $display("FAIL async_reset_out got %b want 1", out1);
        else passed++;
        rst_n = 1'b1;
        #1;
        total++;
        if ({out_q1, sel_q1, cnt1} !== 10'd0) $display("FAIL async_release got out_q=%b sel_q=%b cnt=%0d want 0/0/0", out_q1, sel_q1, cnt1);
        else passed++;
        // Reset asserted exactly on an edge with s=1, en=1, selected=1.
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_q1, sel_q1, cnt1} !== 10'd0) $display("FAIL reset_on_edge got out_q=%b sel_q=%b cnt=%0d want 0/0/0", out_q1, sel_q1, cnt1);
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 255; i++) begin
            s1 = (i % 2 == 0);
            tick();
        end
        total++;
        if (cnt1 !== 8'd255) $display("FAIL wrap_255 got %0d want 255", cnt1);
        else passed++;
        s1 = 1'b0;
        tick();
        total++;
        if (cnt1 !== 8'd0) $display("FAIL wrap_0 got %0d want 0", cnt1);
        else passed++;
        s1 = 1'b1;
        tick();
        total++;
        if (cnt1 !== 8'd1) $display("FAIL wrap_1 got %0d want 1", cnt1);
        else passed++;
        // No change of s: counter must hold.
        tick();
        total++;
        if (cnt1 !== 8'd1) $display("FAIL wrap_hold got %0d want 1", cnt1);
        else passed++;
    endtask

    task automatic test_wide();
        a8 = 8'hA5; b8 = 8'h3C; s8 = 1'b0; en8 = 1'b1;
        #1;
        total++;
        if (out8 !== 8'hA5) $display("FAIL wide_s0 got %h want a5", out8);
        else passed++;
        s8 = 1'b1;
        #1;
        total++;
        if (out8 !== 8'h3C) $display("FAIL wide_s1 got %h want 3c", out8);
        else passed++;
        tick();
        total++;
        if (out_q8 !== 8'h3C) $display("FAIL wide_q got %h want 3c", out_q8);
        else passed++;
        en8 = 1'b0; s8 = 1'b0;
        tick();
        total++;
        if (out_q8 !== 8'h3C || out8 !== 8'hA5) $display("FAIL wide_hold got out_q=%h out=%h want 3c/a5", out_q8, out8);
        else passed++;
        en8 = 1'b1;
        tick();
        total++;
        if (out_q8 !== 8'hA5) $display("FAIL wide_reload got %h want a5", out_q8);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_truth_table();
        test_latency();
        test_enable_hold();
        test_toggle_count();
        test_async_reset();
        test_wrap();
        test_wide();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
